// File: rtl/plab3_mem_securememresponder.sv
// Blocking main-memory responder below the L2. It serves one memreq at a time,
// waits p_latency cycles, and shields a secure address window from insecure requesters.
module plab3_mem_securememresponder #(
    parameter int unsigned p_mem_nbytes   = 1024,
    parameter int unsigned p_opaque_nbits = 8,
    parameter int unsigned p_latency      = 2,
    parameter logic [31:0] p_sec_base     = 32'h0000_0200,
    parameter int unsigned p_sec_nbytes   = 256,
    parameter int unsigned abw            = 32,
    parameter int unsigned clw            = 128
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [3+p_opaque_nbits+abw+4+clw-1:0]  memreq_msg,
    input  logic                                   memreq_val,
    output logic                                   memreq_rdy,
    input  logic                                   insecure,
    output logic [3+p_opaque_nbits+4+clw-1:0]      memresp_msg,
    output logic                                   memresp_val,
    input  logic                                   memresp_rdy,
    output logic                                   sec_viol
);

    localparam int unsigned REQ_NBITS = 3 + p_opaque_nbits + abw + 4 + clw;
    localparam int unsigned IW        = $clog2(p_mem_nbytes) - 4;
    localparam int unsigned NLINES    = p_mem_nbytes / 16;
    localparam int unsigned CW        = (p_latency > 1) ? $clog2(p_latency) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state_q, state_d;

    logic [2:0]                req_type;
    logic [p_opaque_nbits-1:0] req_opaque;
    logic [abw-1:0]            req_addr;
    logic [3:0]                req_len;
    logic [clw-1:0]            req_data;
    logic [IW-1:0]             req_idx;
    logic [4:0]                req_nb;
    logic [63:0]               req_line_addr;
    logic                      req_hit;
    logic                      accept;
    logic                      req_is_wr;
    logic                      req_blocked;

    assign req_type   = memreq_msg[REQ_NBITS-1 -: 3];
    assign req_opaque = memreq_msg[clw+4+abw +: p_opaque_nbits];
    assign req_addr   = memreq_msg[clw+4 +: abw];
    assign req_len    = memreq_msg[clw +: 4];
    assign req_data   = memreq_msg[clw-1:0];
    assign req_idx    = req_addr[IW+3:4];
    assign req_nb     = (req_len == 4'd0) ? 5'd16 : {1'b0, req_len};

    // Window check uses the full (unwrapped) line address.
    assign req_line_addr = 64'({req_addr[abw-1:4], 4'b0000});
    assign req_hit = (p_sec_nbytes != 0)
                  && (req_line_addr >= 64'(p_sec_base))
                  && (req_line_addr <  64'(p_sec_base) + 64'(p_sec_nbytes));

    assign accept      = (state_q == IDLE) && memreq_val;
    assign req_is_wr   = (req_type == 3'd1) || (req_type == 3'd2);
    assign req_blocked = insecure && req_hit && (req_type == 3'd1);

    // Byte-enable mask of the write, clipped at the line end.
    logic [15:0]    wr_bytes;
    logic [clw-1:0] wr_bits;
    logic [clw-1:0] wr_line;

    assign wr_bytes = 16'((17'd1 << req_nb) - 17'd1) << req_addr[3:0];
    assign wr_line  = req_data << {req_addr[3:0], 3'b000};

    always_comb begin
        wr_bits = '0;
        for (int unsigned j = 0; j < 16; j++) begin
            wr_bits[8*j +: 8] = {8{wr_bytes[j]}};
        end
    end

    logic [clw-1:0] mem [NLINES];

    always_ff @(posedge clk) begin
        if (accept && req_is_wr && !req_blocked) begin
            mem[req_idx] <= (mem[req_idx] & ~wr_bits) | (wr_line & wr_bits);
        end
    end

    logic [2:0]                type_q;
    logic [p_opaque_nbits-1:0] opaque_q;
    logic [3:0]                len_q;
    logic [3:0]                off_q;
    logic [IW-1:0]             idx_q;
    logic                      blank_q;
    logic [CW-1:0]             cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            type_q   <= '0;
            opaque_q <= '0;
            len_q    <= '0;
            off_q    <= '0;
            idx_q    <= '0;
            blank_q  <= 1'b0;
            cnt_q    <= '0;
            sec_viol <= 1'b0;
        end else begin
            sec_viol <= accept && insecure && req_hit && (req_type != 3'd2);
            if (accept) begin
                type_q   <= req_type;
                opaque_q <= req_opaque;
                len_q    <= req_len;
                off_q    <= req_addr[3:0];
                idx_q    <= req_idx;
                blank_q  <= insecure && req_hit;
                cnt_q    <= (p_latency > 0) ? CW'(p_latency - 1) : '0;
            end else if ((state_q == WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (memreq_val) state_d = (p_latency > 0) ? WAIT : RESP;
            WAIT: if (cnt_q == '0) state_d = RESP;
            RESP: if (memresp_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign memreq_rdy  = (state_q == IDLE);
    assign memresp_val = (state_q == RESP);

    // Storage is frozen while busy, so a combinational read stays stable in RESP.
    logic [clw-1:0] rd_line;
    logic [15:0]    rd_bytes;
    logic [clw-1:0] rd_bits;
    logic [clw-1:0] resp_data;
    logic [4:0]     nb_q;

    assign nb_q     = (len_q == 4'd0) ? 5'd16 : {1'b0, len_q};
    assign rd_line  = mem[idx_q] >> {off_q, 3'b000};
    assign rd_bytes = 16'((17'd1 << nb_q) - 17'd1);

    always_comb begin
        rd_bits = '0;
        for (int unsigned j = 0; j < 16; j++) begin
            rd_bits[8*j +: 8] = {8{rd_bytes[j]}};
        end
        if ((type_q == 3'd1) || (type_q == 3'd2) || blank_q) begin
            resp_data = '0;
        end else begin
            resp_data = rd_line & rd_bits;
        end
        memresp_msg = '0;
        if (state_q == RESP) begin
            memresp_msg = {type_q, opaque_q, len_q, resp_data};
        end
    end

endmodule
